// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
// Shared audio definitions for the PCM/I2S blocks.
//   DEFAULT_NUMBER_OF_BITS : default PCM sample width
//   WS_LEFT / WS_RIGHT     : word-select encoding (0 = left, 1 = right)
//   i2s_state_t            : IDLE/RUN encoding of the I2S master sequencer
// ---------------------------------------------------------------------------
package audio_pkg;

    localparam int DEFAULT_NUMBER_OF_BITS = 8;

    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } i2s_state_t;

endpackage

// File: rtl/i2s_sck_gen.sv
// ---------------------------------------------------------------------------
// i2s_sck_gen
// Bit-clock generator for an I2S master. While enabled, divides clk so that
// sck toggles every SCK_DIV clk cycles. While disabled the divider and sck
// are held at 0, so re-enabling always starts with a full low half-period.
//   clk, reset    : system clock, synchronous active-high reset
//   enable        : run the divider
//   sck           : registered bit clock
//   shift_event   : high in the cycle whose closing edge takes sck 1->0;
//                   the consumer updates its serial outputs on that edge
// ---------------------------------------------------------------------------
module i2s_sck_gen #(
    parameter int SCK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic sck,
    output logic shift_event
);

    localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_r;
    logic             sck_r;
    logic             wrap_s;

    assign wrap_s      = enable && (div_cnt_r == DIV_LAST);
    assign shift_event = wrap_s && sck_r;
    assign sck         = sck_r;

    // Divider counter and bit-clock toggle
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_r <= DIV_ZERO;
            sck_r     <= 1'b0;
        end else if (!enable) begin
            div_cnt_r <= DIV_ZERO;
            sck_r     <= 1'b0;
        end else if (wrap_s) begin
            div_cnt_r <= DIV_ZERO;
            sck_r     <= ~sck_r;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
        end
    end

endmodule

// File: rtl/pcm_to_i2s.sv
// ---------------------------------------------------------------------------
// pcm_to_i2s
// Serialises left/right PCM sample pairs into an I2S master stream.
// One pair per frame is accepted over valid/ready into a staging register
// and copied into the frame register at each frame start. A frame start
// with nothing staged sends a muted (all-zero) frame and pulses underrun.
//   clk, reset                  : system clock, synchronous active-high reset
//   sample_left/right           : two's complement PCM samples
//   sample_valid / sample_ready : producer handshake (ready = staging empty)
//   sck, ws, sd                 : I2S bit clock, word select, serial data
//   frame_start                 : one-cycle pulse on every frame load
//   underrun                    : one-cycle pulse on a muted frame start
//   underrun_count              : saturating muted-frame count, present
//                                 only when PCM_TO_I2S_UNDERRUN_COUNT_EN
//                                 is defined
// ---------------------------------------------------------------------------
module pcm_to_i2s
    import audio_pkg::*;
#(
    parameter int NUMBER_OF_BITS = DEFAULT_NUMBER_OF_BITS,
    parameter int SLOT_BITS      = 16,
    parameter int SCK_DIV        = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUMBER_OF_BITS-1:0] sample_left,
    input  logic [NUMBER_OF_BITS-1:0] sample_right,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    output logic                      sck,
    output logic                      ws,
    output logic                      sd,
    output logic                      frame_start,
    output logic                      underrun
`ifdef PCM_TO_I2S_UNDERRUN_COUNT_EN
    ,
    output logic [15:0]               underrun_count
`endif
);

    localparam int CNT_W = $clog2(2 * SLOT_BITS);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(2 * SLOT_BITS - 1);
    localparam logic [CNT_W-1:0] SLOT_LEN    = CNT_W'(SLOT_BITS);
    localparam logic [CNT_W-1:0] LAST_DATA_K = CNT_W'(NUMBER_OF_BITS);
    localparam logic [NUMBER_OF_BITS-1:0] SAMPLE_ZERO = {NUMBER_OF_BITS{1'b0}};
    localparam logic [NUMBER_OF_BITS-1:0] SAMPLE_ONE  = NUMBER_OF_BITS'(1);

    i2s_state_t                state_r, state_s;
    logic                      staged_full_r, staged_full_s;
    logic [NUMBER_OF_BITS-1:0] staged_left_r, staged_left_s;
    logic [NUMBER_OF_BITS-1:0] staged_right_r, staged_right_s;
    logic [NUMBER_OF_BITS-1:0] frame_left_r, frame_left_s;
    logic [NUMBER_OF_BITS-1:0] frame_right_r, frame_right_s;
    logic [CNT_W-1:0]          bit_cnt_r, bit_cnt_s;
    logic                      ws_r, ws_s;
    logic                      sd_r, sd_s;
    logic                      frame_start_r, frame_start_s;
    logic                      underrun_r, underrun_s;

    logic                      accept_s;
    logic                      sck_enable_s;
    logic                      shift_event_s;
    logic [CNT_W-1:0]          next_bit_s;
    logic [CNT_W-1:0]          slot_pos_s;
    logic                      next_ws_s;
    logic                      next_sd_s;
    logic [NUMBER_OF_BITS-1:0] chan_s;
    logic [NUMBER_OF_BITS-1:0] bit_mask_s;

    assign accept_s     = sample_valid && !staged_full_r;
    assign sck_enable_s = (state_r == ST_RUN);

    i2s_sck_gen #(
        .SCK_DIV (SCK_DIV)
    ) u_sck_gen (
        .clk         (clk),
        .reset       (reset),
        .enable      (sck_enable_s),
        .sck         (sck),
        .shift_event (shift_event_s)
    );

    // Look-ahead of ws/sd for the bit position entered on the next shift
    always_comb begin
        next_bit_s = CNT_ZERO;
        slot_pos_s = CNT_ZERO;
        next_ws_s  = WS_LEFT;
        chan_s     = frame_left_r;
        bit_mask_s = SAMPLE_ZERO;
        if (bit_cnt_r == CNT_LAST) begin
            next_bit_s = CNT_ZERO;
        end else begin
            next_bit_s = bit_cnt_r + CNT_ONE;
        end
        if (next_bit_s >= SLOT_LEN) begin
            next_ws_s  = WS_RIGHT;
            slot_pos_s = next_bit_s - SLOT_LEN;
            chan_s     = frame_right_r;
        end else begin
            next_ws_s  = WS_LEFT;
            slot_pos_s = next_bit_s;
            chan_s     = frame_left_r;
        end
        // Slot position 0 is the one-SCK WS lead; data sits at 1..NUMBER_OF_BITS
        if ((slot_pos_s != CNT_ZERO) && (slot_pos_s <= LAST_DATA_K)) begin
            bit_mask_s = SAMPLE_ONE << (LAST_DATA_K - slot_pos_s);
        end else begin
            bit_mask_s = SAMPLE_ZERO;
        end
        next_sd_s = |(chan_s & bit_mask_s);
    end

    // Sequencer next state: frame loads, bit advance, staging handshake
    always_comb begin
        state_s        = state_r;
        staged_full_s  = staged_full_r;
        staged_left_s  = staged_left_r;
        staged_right_s = staged_right_r;
        frame_left_s   = frame_left_r;
        frame_right_s  = frame_right_r;
        bit_cnt_s      = bit_cnt_r;
        ws_s           = ws_r;
        sd_s           = sd_r;
        frame_start_s  = 1'b0;
        underrun_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (staged_full_r) begin
                    state_s       = ST_RUN;
                    frame_left_s  = staged_left_r;
                    frame_right_s = staged_right_r;
                    staged_full_s = 1'b0;
                    bit_cnt_s     = CNT_ZERO;
                    ws_s          = WS_LEFT;
                    sd_s          = 1'b0;
                    frame_start_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (shift_event_s) begin
                    bit_cnt_s = next_bit_s;
                    ws_s      = next_ws_s;
                    sd_s      = next_sd_s;
                    if (next_bit_s == CNT_ZERO) begin
                        frame_start_s = 1'b1;
                        if (staged_full_r) begin
                            frame_left_s  = staged_left_r;
                            frame_right_s = staged_right_r;
                            staged_full_s = 1'b0;
                        end else begin
                            frame_left_s  = SAMPLE_ZERO;
                            frame_right_s = SAMPLE_ZERO;
                            underrun_s    = 1'b1;
                        end
                    end else begin
                        frame_start_s = 1'b0;
                    end
                end else begin
                    bit_cnt_s = bit_cnt_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // Accept only when staging is empty, so it never collides with a load
        if (accept_s) begin
            staged_full_s  = 1'b1;
            staged_left_s  = sample_left;
            staged_right_s = sample_right;
        end else begin
            staged_full_s = staged_full_s;
        end
    end

    // Sequencer and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            staged_full_r  <= 1'b0;
            staged_left_r  <= SAMPLE_ZERO;
            staged_right_r <= SAMPLE_ZERO;
            frame_left_r   <= SAMPLE_ZERO;
            frame_right_r  <= SAMPLE_ZERO;
            bit_cnt_r      <= CNT_ZERO;
            ws_r           <= WS_LEFT;
            sd_r           <= 1'b0;
            frame_start_r  <= 1'b0;
            underrun_r     <= 1'b0;
        end else begin
            state_r        <= state_s;
            staged_full_r  <= staged_full_s;
            staged_left_r  <= staged_left_s;
            staged_right_r <= staged_right_s;
            frame_left_r   <= frame_left_s;
            frame_right_r  <= frame_right_s;
            bit_cnt_r      <= bit_cnt_s;
            ws_r           <= ws_s;
            sd_r           <= sd_s;
            frame_start_r  <= frame_start_s;
            underrun_r     <= underrun_s;
        end
    end

    assign sample_ready = ~staged_full_r;
    assign ws           = ws_r;
    assign sd           = sd_r;
    assign frame_start  = frame_start_r;
    assign underrun     = underrun_r;

`ifdef PCM_TO_I2S_UNDERRUN_COUNT_EN
    logic [15:0] underrun_count_r;

    // Saturating tally of muted frames, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_count_r <= 16'h0000;
        end else if (underrun_s && (underrun_count_r != 16'hFFFF)) begin
            underrun_count_r <= underrun_count_r + 16'h0001;
        end
    end

    assign underrun_count = underrun_count_r;
`endif

endmodule
